// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Optional FRAME_DONE_EN adds a registered end-of-frame pulse on the frame_done port.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] in3,
    output logic [7:0] in4,
    output logic [7:0] in5,
    output logic [7:0] in6,
    output logic [7:0] in7,
    output logic [7:0] in8,
    output logic [7:0] in9,
    output logic       window_valid
`ifdef FRAME_DONE_EN
    ,
    output logic       frame_done
`endif
);

    // Handshake: pixel_valid is a one-sided strobe; pixel_in is taken on every
    // rising edge where pixel_valid is high and there is no ready/backpressure.

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb0_rd;
    logic [7:0] lb1_rd;

    logic col_last;
    logic row_last;
    logic in_interior;

    assign lb0_rd      = lb0[col];
    assign lb1_rd      = lb1[col];
    assign col_last    = (col == COL_LAST);
    assign row_last    = (row == ROW_LAST);
    // Columns 0 and 1 hold stale pixels from the previous line, so they never qualify.
    assign in_interior = (row >= ROW_TWO) && (col >= COL_TWO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are deliberately not reset; qualification keeps stale data invisible.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1 <= '0;
            in2 <= '0;
            in3 <= '0;
            in4 <= '0;
            in5 <= '0;
            in6 <= '0;
            in7 <= '0;
            in8 <= '0;
            in9 <= '0;
        end else if (pixel_valid) begin
            in1 <= in2;
            in2 <= in3;
            in3 <= lb1_rd;
            in4 <= in5;
            in5 <= in6;
            in6 <= lb0_rd;
            in7 <= in8;
            in8 <= in9;
            in9 <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_valid <= 1'b0;
        end else begin
            window_valid <= pixel_valid && in_interior;
        end
    end

`ifdef FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pixel_valid && col_last && row_last;
        end
    end
`endif

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001: IMG_WIDTH, default 512, pixels per line (>= 3).
REQ-002: IMG_HEIGHT, default 512, lines per frame (>= 3).
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005: pixel_in  input  8  raster-order pixel, left-to-right, top-to-bottom.
REQ-006: pixel_valid  input  1  pixel_in accepted on every clock edge where this is high; no backpressure.
REQ-007: in1..in9  output  8 each  registered 3x3 window; in1-in3 top row, in4-in6 middle, in7-in9 bottom; left-to-right within a row; in9 = newest pixel.
REQ-008: window_valid  output  1  high for one cycle per complete window.
REQ-009: frame_done  output  1  present only with FRAME_DONE_EN (see Configuration).

Function
REQ-010: Column counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1, each $clog2-wide, shall advance only on accepted pixels.
REQ-011: At col = IMG_WIDTH-1 the column shall wrap to 0 and the row shall increment; at (IMG_WIDTH-1, IMG_HEIGHT-1) both shall wrap to 0, starting a new frame with no idle cycle.
REQ-012: Two line buffers of IMG_WIDTH x 8 bits: LB0 holds row r-1, LB1 holds row r-2. On an accepted pixel at column c, LB1[c] <= LB0[c] and LB0[c] <= pixel_in; reads use pre-write values.
REQ-013: On an accepted pixel, shift: in1<=in2, in2<=in3, in3<=LB1[c]; in4<=in5, in5<=in6, in6<=LB0[c]; in7<=in8, in8<=in9, in9<=pixel_in.
REQ-014: window_valid shall be registered as pixel_valid AND row >= 2 AND col >= 2 (the counters before the advance), giving a latency of 1 cycle from the accepting edge to the window.
REQ-015: Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame; window centered on pixel (row-1, col-1); no border padding or border windows.
REQ-016: When pixel_valid is low, counters, line buffers and in1..in9 shall hold and window_valid shall be 0.
REQ-017: The column shift registers may carry stale data across a line boundary; window_valid shall stay low for col 0 and col 1 so that stale data is never flagged valid.
REQ-018: Throughput is one window per clock at sustained pixel_valid.

Reset
REQ-019: While rst = 0: counters = 0, in1..in9 = 0, window_valid = 0, frame_done = 0, asynchronously.
REQ-020: Line buffer contents are not reset; reset gating of REQ-014 ensures stale contents are never flagged valid.
REQ-021: Reset mid-frame shall abandon the frame; the first accepted pixel after release shall be treated as (0,0).

Configuration
REQ-022: Macro FRAME_DONE_EN: when defined, the frame_done port exists and pulses high for one cycle, registered, on the cycle after accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1), coincident with the final window_valid.
REQ-023: Without FRAME_DONE_EN, the frame_done port and its logic shall be absent; all other behaviour is identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*4+col)
REQ-024: Continuous valid frame -> exactly 4 windows; the first, after pixel 10, is in1..in9 = 0,1,2,4,5,6,8,9,10; the last is 5,6,7,9,10,11,13,14,15.
REQ-025: pixel_valid toggled 1,0,1,0 through the frame -> the same 4 windows with identical values; window_valid never high on a cycle following pixel_valid = 0.
REQ-026: Two back-to-back frames, second frame offset by +100 -> the second frame's first window is 100,101,102,104,105,106,108,109,110, with no stale first-frame data.
REQ-027: rst pulsed low after pixel 6, then a fresh full frame -> outputs are 0 during reset, and exactly 4 correct windows follow as in REQ-024.
REQ-028: With FRAME_DONE_EN, two frames -> frame_done high exactly 2 cycles total, each coincident with the last window_valid of its frame; without the macro, the build has no frame_done port.
